evg_event_mux: RTL and testbench

- Single-clock event arbiter directly downstream of the EVG sequencer, in the transmitter clock domain.
- Merges three event sources into the one-code-per-cycle transmit stream:
  - sequencer events (no back-pressure),
  - software event requests (AXI-Stream style, with back-pressure),
  - the heartbeat request.
- Sequencer events are never delayed or dropped. Lower-priority sources are buffered and fill free slots.

---
 rtl/evg_event_mux.sv | 125 ++++++++++++
 tb/tb_evg_event_mux.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/evg_event_mux.sv
// EVG event arbiter: merges sequencer, software FIFO and heartbeat events into one code per cycle.
// Optional heartbeat latency tracking is enabled by defining EVG_EVENT_MUX_HB_LATENCY_EN.
module evg_event_mux #(
    parameter int                         EVENTCODE_WIDTH      = 8,
    parameter int                         SW_FIFO_DEPTH        = 16,
    parameter logic [EVENTCODE_WIDTH-1:0] HEARTBEAT_EVENT_CODE = 8'h7A,
    parameter logic [EVENTCODE_WIDTH-1:0] IDLE_EVENT_CODE      = 8'h00
) (
    input  logic                             evgTxClk,
    input  logic                             evgTxReset,
    input  logic [EVENTCODE_WIDTH-1:0]       evgSequenceEventTDATA,
    input  logic                             evgSequenceEventTVALID,
    input  logic [EVENTCODE_WIDTH-1:0]       evgSwEventTDATA,
    input  logic                             evgSwEventTVALID,
    output logic                             evgSwEventTREADY,
    input  logic                             evgHeartbeatRequest,
    output logic [EVENTCODE_WIDTH-1:0]       evgTxCode,
    output logic                             evgTxCodeValid,
    output logic [7:0]                       heartbeatMissed,
    output logic [$clog2(SW_FIFO_DEPTH):0]   swFifoLevel,
    output logic [7:0]                       heartbeatMaxWait
);

    localparam int AW = $clog2(SW_FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [AW:0] FULL_LEVEL = PW'(SW_FIFO_DEPTH);

    logic [EVENTCODE_WIDTH-1:0] swMem [SW_FIFO_DEPTH];
    logic [AW:0]                wrPtrReg, rdPtrReg;
    logic [AW:0]                fifoLevel, levelNext;
    logic                       fifoEmpty;
    logic                       readyReg;
    logic                       hbPendingReg;
    logic [7:0]                 missedReg;
    logic [EVENTCODE_WIDTH-1:0] txCodeReg;
    logic                       txValidReg;

    logic seqReq, hbEmit, swPop, swAccept, swPush;

    // Pointers carry one extra bit so a full FIFO is distinguishable from an empty one.
    assign fifoLevel = wrPtrReg - rdPtrReg;
    assign fifoEmpty = (fifoLevel == '0);

    assign seqReq   = evgSequenceEventTVALID && (evgSequenceEventTDATA != IDLE_EVENT_CODE);
    assign hbEmit   = !seqReq && hbPendingReg;
    assign swPop    = !seqReq && !hbPendingReg && !fifoEmpty;
    assign swAccept = evgSwEventTVALID && readyReg;
    assign swPush   = swAccept && (evgSwEventTDATA != IDLE_EVENT_CODE);

    assign levelNext = fifoLevel + {{AW{1'b0}}, swPush} - {{AW{1'b0}}, swPop};

    always_ff @(posedge evgTxClk) begin
        if (swPush) begin
            swMem[wrPtrReg[AW-1:0]] <= evgSwEventTDATA;
        end
    end

    always_ff @(posedge evgTxClk) begin
        if (evgTxReset) begin
            wrPtrReg     <= '0;
            rdPtrReg     <= '0;
            readyReg     <= 1'b1;
            hbPendingReg <= 1'b0;
            missedReg    <= '0;
            txCodeReg    <= IDLE_EVENT_CODE;
            txValidReg   <= 1'b0;
        end else begin
            if (seqReq) begin
                txCodeReg  <= evgSequenceEventTDATA;
                txValidReg <= 1'b1;
            end else if (hbPendingReg) begin
                txCodeReg  <= HEARTBEAT_EVENT_CODE;
                txValidReg <= 1'b1;
            end else if (!fifoEmpty) begin
                txCodeReg  <= swMem[rdPtrReg[AW-1:0]];
                txValidReg <= 1'b1;
            end else begin
                txCodeReg  <= IDLE_EVENT_CODE;
                txValidReg <= 1'b0;
            end

            if (swPush) wrPtrReg <= wrPtrReg + 1'b1;
            if (swPop)  rdPtrReg <= rdPtrReg + 1'b1;
            readyReg <= (levelNext != FULL_LEVEL);

            // A strobe landing on the emission cycle re-arms the flag without counting as missed.
            hbPendingReg <= evgHeartbeatRequest || (hbPendingReg && !hbEmit);
            if (evgHeartbeatRequest && hbPendingReg && !hbEmit && missedReg != 8'hFF) begin
                missedReg <= missedReg + 8'd1;
            end
        end
    end

`ifdef EVG_EVENT_MUX_HB_LATENCY_EN
    logic [7:0] waitReg;
    logic [7:0] maxWaitReg;

    always_ff @(posedge evgTxClk) begin
        if (evgTxReset) begin
            waitReg    <= '0;
            maxWaitReg <= '0;
        end else begin
            if (hbEmit && waitReg > maxWaitReg) begin
                maxWaitReg <= waitReg;
            end
            if (evgHeartbeatRequest && (!hbPendingReg || hbEmit)) begin
                waitReg <= '0;
            end else if (hbPendingReg && waitReg != 8'hFF) begin
                waitReg <= waitReg + 8'd1;
            end
        end
    end

    assign heartbeatMaxWait = maxWaitReg;
`else
    assign heartbeatMaxWait = 8'd0;
`endif

    assign evgSwEventTREADY = readyReg;
    assign evgTxCode        = txCodeReg;
    assign evgTxCodeValid   = txValidReg;
    assign heartbeatMissed  = missedReg;
    assign swFifoLevel      = fifoLevel;

endmodule

// File: tb/tb_evg_event_mux.sv
// Scoreboard bench for evg_event_mux: directed test-plan sequences followed by random traffic,
// checked against a queue-based reference model.
module tb_evg_event_mux;

    localparam int DEPTH = 16;
    localparam logic [7:0] HB   = 8'h7A;
    localparam logic [7:0] IDLE = 8'h00;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic [7:0] seqData = '0;
    logic       seqValid = 1'b0;
    logic [7:0] swData = '0;
    logic       swValid = 1'b0;
    logic       swReady;
    logic       hbReq = 1'b0;
    logic [7:0] txCode;
    logic       txValid;
    logic [7:0] hbMissed;
    logic [4:0] swLevel;
    logic [7:0] hbMaxWait;

    always #5 clk = ~clk;

    evg_event_mux dut (
        .evgTxClk               (clk),
        .evgTxReset             (srst),
        .evgSequenceEventTDATA  (seqData),
        .evgSequenceEventTVALID (seqValid),
        .evgSwEventTDATA        (swData),
        .evgSwEventTVALID       (swValid),
        .evgSwEventTREADY       (swReady),
        .evgHeartbeatRequest    (hbReq),
        .evgTxCode              (txCode),
        .evgTxCodeValid         (txValid),
        .heartbeatMissed        (hbMissed),
        .swFifoLevel            (swLevel),
        .heartbeatMaxWait       (hbMaxWait)
    );

    typedef struct {
        int code;
        int valid;
        int level;
        int ready;
        int missed;
        int maxWait;
    } exp_t;

    exp_t expQ[$];
    int   nVectors = 0;
    int   nMiscompares = 0;

    // Reference model state: plain queue for the FIFO, cycle stamps for heartbeat latency.
    logic [7:0] mSwQ[$];
    bit   mPend = 0;
    int   mMissed = 0;
    int   mRiseCycle = 0;
    int   mMaxWait = 0;
    int   cycleNo = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        if (act !== expv) begin
            nMiscompares++;
            $display("FAIL %s at vector %0d: got %0h, expected %0h", name, nVectors, act, expv);
        end
    endtask

    task automatic step(input bit rst, input bit seqV, input logic [7:0] seqD,
                        input bit swV, input logic [7:0] swD, input bit hb, output bit acc);
        exp_t e;
        bit   ready;
        bit   hbOut;
        @(negedge clk);
        srst = rst; seqValid = seqV; seqData = seqD;
        swValid = swV; swData = swD; hbReq = hb;
        acc = 0;
        hbOut = 0;
        if (rst) begin
            mSwQ.delete();
            mPend = 0; mMissed = 0; mMaxWait = 0;
            e.code = IDLE; e.valid = 0;
        end else begin
            ready = (mSwQ.size() < DEPTH);
            acc = swV && ready;
            if (seqV && seqD != IDLE) begin
                e.code = seqD; e.valid = 1;
            end else if (mPend) begin
                e.code = HB; e.valid = 1; hbOut = 1;
            end else if (mSwQ.size() > 0) begin
                e.code = mSwQ.pop_front(); e.valid = 1;
            end else begin
                e.code = IDLE; e.valid = 0;
            end
`ifdef EVG_EVENT_MUX_HB_LATENCY_EN
            if (hbOut) begin
                int w;
                w = cycleNo - mRiseCycle - 1;
                if (w > 255) w = 255;
                if (w > mMaxWait) mMaxWait = w;
            end
`endif
            if (hb) begin
                if (mPend && !hbOut) begin
                    if (mMissed < 255) mMissed++;
                end else begin
                    mRiseCycle = cycleNo;
                end
                mPend = 1;
            end else if (hbOut) begin
                mPend = 0;
            end
            if (acc && swD != IDLE) mSwQ.push_back(swD);
        end
        e.level   = mSwQ.size();
        e.ready   = (mSwQ.size() < DEPTH) ? 1 : 0;
        e.missed  = mMissed;
        e.maxWait = mMaxWait;
        expQ.push_back(e);
        cycleNo++;
    endtask

    task automatic cyc(input bit rst, input bit seqV, input logic [7:0] seqD,
                       input bit swV, input logic [7:0] swD, input bit hb);
        bit acc;
        step(rst, seqV, seqD, swV, swD, hb, acc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0, 8'h00, 0);
    endtask

    // Monitor: the DUT presents a code every cycle; compare it against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            nVectors++;
            $display("vec %0d: code=%02h valid=%0b level=%0d ready=%0b missed=%0d maxWait=%0d",
                     nVectors, txCode, txValid, swLevel, swReady, hbMissed, hbMaxWait);
            chk("evgTxCode", 32'(txCode), e.code);
            chk("evgTxCodeValid", 32'(txValid), e.valid);
            chk("swFifoLevel", 32'(swLevel), e.level);
            chk("evgSwEventTREADY", 32'(swReady), e.ready);
            chk("heartbeatMissed", 32'(hbMissed), e.missed);
            chk("heartbeatMaxWait", 32'(hbMaxWait), e.maxWait);
        end
    end

    initial begin
        bit   acc;
        int   k;
        int   guard;
        int   seqPct;
        logic [7:0] d;
        logic [7:0] s;

        repeat (3) cyc(1, 0, 8'h00, 0, 8'h00, 0);

        // Back-to-back sequencer codes, then idle.
        cyc(0, 1, 8'h21, 0, 8'h00, 0);
        cyc(0, 1, 8'h22, 0, 8'h00, 0);
        cyc(0, 1, 8'h23, 0, 8'h00, 0);
        idle(2);

        // Heartbeat alongside a sequencer code, then two strobes inside a 6-cycle burst.
        cyc(0, 1, 8'h10, 0, 8'h00, 1);
        idle(2);
        for (int i = 0; i < 6; i++) cyc(0, 1, 8'(8'h50 + i), 0, 8'h00, (i == 0 || i == 3));
        idle(3);

        // Fill the software FIFO while the sequencer holds every slot.
        k = 0;
        guard = 0;
        while (k < 16 && guard < 40) begin
            step(0, 1, 8'h60, 1, 8'(8'h30 + k), 0, acc);
            if (acc) k++;
            guard++;
        end
        if (k != 16) begin
            nMiscompares++;
            $display("FAIL fifo_fill: accepted %0d entries, expected 16", k);
        end
        cyc(0, 1, 8'h61, 1, 8'h99, 0);
        cyc(0, 1, 8'h62, 1, 8'h99, 0);
        idle(20);

        // Idle code on the software stream is accepted but never emitted.
        cyc(0, 0, 8'h00, 1, 8'h00, 0);
        cyc(0, 0, 8'h00, 1, 8'h44, 0);
        idle(4);

        // Heartbeat held off by a 9-cycle burst, then an unblocked one.
        cyc(0, 0, 8'h00, 0, 8'h00, 1);
        for (int i = 0; i < 9; i++) cyc(0, 1, 8'(8'h70 + i), 0, 8'h00, 0);
        idle(3);
        cyc(0, 0, 8'h00, 0, 8'h00, 1);
        idle(3);

        // Mid-operation reset with queued software codes and a pending heartbeat.
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'h11, 1, 8'(8'hA0 + i), (i == 4));
        cyc(1, 0, 8'h00, 0, 8'h00, 0);
        idle(5);

        // Randomized traffic with varying sequencer load.
        for (int i = 0; i < 3000; i++) begin
            seqPct = (i / 250) % 4 == 0 ? 10 : (i / 250) % 4 == 1 ? 50 :
                     (i / 250) % 4 == 2 ? 90 : 100;
            s = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            cyc(($urandom_range(0, 399) == 0),
                ($urandom_range(0, 99) < seqPct), s,
                ($urandom_range(0, 1) == 1), d,
                ($urandom_range(0, 5) == 0));
        end
        idle(40);

        repeat (3) @(posedge clk);
        #2;
        if (expQ.size() != 0) begin
            nMiscompares++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
